multi_db_fsm: RTL
=================

# multi_db_fsm

Parametrised N-channel switch debouncer that generalises the single-channel early-response debouncer. Each channel has its own runtime-selectable mode: early mode (output follows the first edge immediately, then locks out) or delayed mode (output changes only after the input has been stable for the full debounce interval). A shared prescaler drives all channels. The block sits between raw push-button/switch pins and the user logic, and provides a debounced level plus one-cycle rise and fall pulses per channel.

## Interface
- N, default 4: number of channels, ≥1.
- TICK_DIV, default 100000: clock cycles per debounce tick, ≥2. At 100 MHz the default gives a 1 ms tick.
- LOCK_TICKS, default 20: ticks per debounce interval, ≥1. The default gives 20 ms.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sw  in  N  raw asynchronous switch inputs.
- mode  in  N  per-channel mode: 0 = early/lockout, 1 = delayed/stable. Sampled only in the STABLE state.
- db  out  N  debounced level.
- rise  out  N  one-cycle pulse in the cycle db goes 0→1.
- fall  out  N  one-cycle pulse in the cycle db goes 1→0.
- busy  out  N  high while the channel is in the LOCK or WAIT state.

## Operation
- Synchronizer: two flops per channel (s1, s2). FSM decisions use s2 only.
- Prescaler: shared counter that runs 0..TICK_DIV-1 and wraps. tick = (count == TICK_DIV-1). It free-runs independently of channel activity.
- Per-channel state: STABLE, LOCK, WAIT. Each channel has a tick counter tc of width clog2(LOCK_TICKS+1).
- STABLE, s2 == db: stay.
- STABLE, s2 != db, mode = 0:
  - Toggle db and pulse rise or fall.
  - tc←0, go to LOCK.
- STABLE, s2 != db, mode = 1: tc←0, go to WAIT. db is unchanged.
- LOCK:
  - s2 is ignored.
  - On tick, tc←tc+1.
  - On the tick where tc == LOCK_TICKS-1, go to STABLE.
  - If s2 still differs from db at that point, STABLE toggles db on the next edge.
- WAIT, s2 == db: go to STABLE, tc←0. No output change; the bounce is rejected.
- WAIT, s2 != db, tick, and tc == LOCK_TICKS-1:
  - Toggle db and pulse, on the same edge.
  - Go to STABLE.
  - No lockout follows.
- WAIT, s2 != db, otherwise: on tick, tc←tc+1.
- A tick coinciding with the entry edge into LOCK/WAIT is not counted.
- A mode change during LOCK/WAIT takes effect only on return to STABLE.
- Channels are fully independent. Simultaneous events on any subset of channels are handled in parallel.
- rise and fall are mutually exclusive per channel. Each is high for exactly one cycle.

## Timing
- Reset values:
  - db, rise, fall, busy = 0.
  - s1, s2 = 0.
  - Every channel in STABLE, all tc = 0, prescaler = 0.
- Reset asserted mid-LOCK/WAIT returns the channel to reset values on that edge. Any pending pulse is dropped.
- Mode 0 latency: if sw changes before edge k, s1 updates at k, s2 at k+1, and db/pulse register at k+2.
- LOCK duration and WAIT-to-toggle delay, measured from the entry edge: between (LOCK_TICKS-1)·TICK_DIV+1 and LOCK_TICKS·TICK_DIV cycles.
- busy rises on the LOCK/WAIT entry edge and falls on the exit edge.

## Test plan
Bench parameters: N=4, TICK_DIV=10, LOCK_TICKS=5. The debounce window is 41..50 cycles.
- Reset, then idle 20 cycles:
  - db=0, rise=fall=busy=0.
  - Prescaler wraps every 10 cycles.
- Ch0, mode=0, sw 0→1 with bounces at +5, +10, +15 cycles, then held high:
  - db[0] rises 3 edges after the first edge.
  - rise[0] is a single-cycle pulse.
  - busy[0] stays high for 41..50 cycles.
  - No further pulses occur.
- Ch1, mode=1, sw high for 20 cycles then low:
  - db[1] stays 0, no pulses.
  - busy[1] drops when s2 returns to 0.
  - Then sw is held high for 60 cycles: db[1] rises 41..50 cycles after s2 goes high, with one rise pulse.
- Ch0 mode=0, sw toggles back to 0 during LOCK and stays low:
  - fall[0] fires one cycle after LOCK exit.
  - A second 41..50-cycle lock follows.
- All 4 channels with mixed modes, simultaneous edges: each channel meets its own timing independently, with no cross-channel interference.
- Reset asserted mid-WAIT on ch2 (mode=1):
  - All outputs are 0 on the next edge.
  - After release with sw still high, a fresh 41..50-cycle wait completes before db[2] rises.

Source files
------------

// File: rtl/multi_db_fsm.sv
// N-channel switch debouncer. A shared prescaler ticks every TICK_DIV cycles, and each
// channel runs its own early/lockout or delayed/stable FSM selected by mode.

module multi_db_ch #(
  parameter int LOCK_TICKS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sw,
  input  logic i_mode,
  input  logic i_tick,
  output logic o_db,
  output logic o_rise,
  output logic o_fall,
  output logic o_busy
);
  localparam int TW = $clog2(LOCK_TICKS + 1);
  localparam logic [TW-1:0] TC_LAST = TW'(LOCK_TICKS - 1);

  typedef enum logic [1:0] {ST_STABLE, ST_LOCK, ST_WAIT} state_t;

  state_t          r_state, w_state_n;
  logic [TW-1:0]   r_tc, w_tc_n;
  logic            r_s1, r_s2, r_db, r_rise, r_fall;
  logic            w_db_n, w_rise_n, w_fall_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_STABLE;
      r_tc    <= '0;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_db    <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_tc    <= w_tc_n;
      r_s1    <= i_sw;
      r_s2    <= r_s1;
      r_db    <= w_db_n;
      r_rise  <= w_rise_n;
      r_fall  <= w_fall_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_tc_n    = r_tc;
    w_db_n    = r_db;
    w_rise_n  = 1'b0;
    w_fall_n  = 1'b0;
    case (r_state)
      ST_STABLE: begin
        if (r_s2 != r_db) begin
          w_tc_n = '0;
          if (!i_mode) begin
            w_db_n    = ~r_db;
            w_rise_n  = ~r_db;
            w_fall_n  = r_db;
            w_state_n = ST_LOCK;
          end else begin
            w_state_n = ST_WAIT;
          end
        end
      end
      // Input is ignored while locked; a still-differing s2 re-toggles from STABLE.
      ST_LOCK: begin
        if (i_tick) begin
          if (r_tc == TC_LAST) w_state_n = ST_STABLE;
          else                 w_tc_n    = r_tc + 1'b1;
        end
      end
      ST_WAIT: begin
        if (r_s2 == r_db) begin
          w_state_n = ST_STABLE;
          w_tc_n    = '0;
        end else if (i_tick) begin
          if (r_tc == TC_LAST) begin
            w_db_n    = ~r_db;
            w_rise_n  = ~r_db;
            w_fall_n  = r_db;
            w_state_n = ST_STABLE;
          end else begin
            w_tc_n = r_tc + 1'b1;
          end
        end
      end
      default: w_state_n = ST_STABLE;
    endcase
  end

  assign o_db   = r_db;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
  assign o_busy = (r_state != ST_STABLE);
endmodule

module multi_db_fsm #(
  parameter int N          = 4,
  parameter int TICK_DIV   = 100000,
  parameter int LOCK_TICKS = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] sw,
  input  logic [N-1:0] mode,
  output logic [N-1:0] db,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] busy
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_pcnt;
  logic          w_tick;

  assign w_tick = (r_pcnt == PC_LAST);

  always_ff @(posedge clk) begin
    if (reset)       r_pcnt <= '0;
    else if (w_tick) r_pcnt <= '0;
    else             r_pcnt <= r_pcnt + 1'b1;
  end

  for (genvar g = 0; g < N; g++) begin : g_ch
    multi_db_ch #(.LOCK_TICKS(LOCK_TICKS)) u_ch (
      .clk    (clk),
      .reset  (reset),
      .i_sw   (sw[g]),
      .i_mode (mode[g]),
      .i_tick (w_tick),
      .o_db   (db[g]),
      .o_rise (rise[g]),
      .o_fall (fall[g]),
      .o_busy (busy[g])
    );
  end
endmodule
